reset_seq_ctrl: RTL

//  Reset/clock-enable sequencer for d_ff-style datapath banks. Takes the board async reset, synchronises its release, runs the

---
 rtl/reset_seq_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/reset_seq_ctrl.sv
// Reset / clock-enable sequencer: synchronises board reset release, holds sync reset with the clock running,
// releases staged async resets one by one, then serves a 4-phase soft-reset handshake.
module reset_seq_ctrl #(
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned N_STAGES  = 3,
  parameter int unsigned STAGE_GAP = 2,
  parameter int unsigned SOFT_LEN  = 3
) (
  input  logic                clk,
  input  logic                async_reset_n,
  input  logic                i_soft_req,
  output logic                o_clk_enable,
  output logic                o_sync_reset,
  output logic [N_STAGES-1:0] o_stage_rst_n,
  output logic                o_ready,
  output logic                o_soft_ack,
  output logic [2:0]          o_state
);

  localparam int unsigned MAX_HG  = (RST_HOLD > STAGE_GAP) ? RST_HOLD : STAGE_GAP;
  localparam int unsigned MAX_CNT = (MAX_HG > SOFT_LEN) ? MAX_HG : SOFT_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  if (RST_HOLD < 1 || STAGE_GAP < 1 || SOFT_LEN < 1 || N_STAGES < 1 || N_STAGES > 8) begin : g_param_err
    $error("reset_seq_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_CLKON = 3'd1,
    ST_STAGE = 3'd2,
    ST_RUN   = 3'd3,
    ST_SOFT  = 3'd4
  } state_e;

  logic [1:0]          sync_q;
  logic                rst_sync_n;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clk_en_q, clk_en_d;
  logic                sync_rst_q, sync_rst_d;
  logic [N_STAGES-1:0] stage_q, stage_d;
  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic [N_STAGES-1:0] stage_nxt;
  logic                stage_last;
  logic                hold_done, gap_done, soft_done;

  // Two-flop release synchroniser; assertion clears it asynchronously.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[1];

  // Stage resets release by shifting a 1 in from bit 0; the last release is the one that fills the vector.
  assign stage_nxt  = N_STAGES'({stage_q, 1'b1});
  assign stage_last = &stage_nxt;
  assign hold_done  = (cnt_q == CNT_W'(RST_HOLD - 1));
  assign gap_done   = (cnt_q == CNT_W'(STAGE_GAP - 1));
  assign soft_done  = (cnt_q == CNT_W'(SOFT_LEN - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    clk_en_d   = clk_en_q;
    sync_rst_d = sync_rst_q;
    stage_d    = stage_q;
    ready_d    = ready_q;
    ack_d      = ack_q;

    case (state_q)
      ST_RESET: begin
        cnt_d      = '0;
        clk_en_d   = 1'b0;
        sync_rst_d = 1'b1;
        ready_d    = 1'b0;
        ack_d      = 1'b0;
        if (rst_sync_n) begin
          state_d  = ST_CLKON;
          clk_en_d = 1'b1;
        end
      end

      ST_CLKON: begin
        if (hold_done) begin
          cnt_d   = '0;
          stage_d = stage_nxt;
          if (stage_last) begin
            state_d    = ST_RUN;
            sync_rst_d = 1'b0;
            ready_d    = 1'b1;
          end else begin
            state_d = ST_STAGE;
          end
        end
      end

      ST_STAGE: begin
        if (gap_done) begin
          cnt_d   = '0;
          stage_d = stage_nxt;
          if (stage_last) begin
            state_d    = ST_RUN;
            sync_rst_d = 1'b0;
            ready_d    = 1'b1;
          end
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        // Ack is held until the requester drops its level; a held request cannot retrigger.
        ack_d = ack_q & i_soft_req;
        if (i_soft_req && !ack_q) begin
          state_d    = ST_SOFT;
          sync_rst_d = 1'b1;
          ready_d    = 1'b0;
        end
      end

      ST_SOFT: begin
        if (soft_done) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          sync_rst_d = 1'b0;
          ready_d    = 1'b1;
          ack_d      = 1'b1;
        end
      end

      default: begin
        state_d    = ST_RESET;
        cnt_d      = '0;
        clk_en_d   = 1'b0;
        sync_rst_d = 1'b1;
        ready_d    = 1'b0;
        ack_d      = 1'b0;
      end
    endcase
  end

  // State, counter and all outputs share one register stage.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      clk_en_q   <= 1'b0;
      sync_rst_q <= 1'b1;
      stage_q    <= '0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      sync_rst_q <= sync_rst_d;
      stage_q    <= stage_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
    end
  end

  assign o_clk_enable  = clk_en_q;
  assign o_sync_reset  = sync_rst_q;
  assign o_stage_rst_n = stage_q;
  assign o_ready       = ready_q;
  assign o_soft_ack    = ack_q;
  assign o_state       = state_q;

endmodule
